// File: rtl/riscv_hpm_unit_if.sv
// ---------------------------------------------------------------------------
// riscv_hpm_unit_if
// CSR access bundle between the CSR file (master) and the performance-counter
// unit (slave).
//   csr_addr_i    : 12-bit CSR address
//   csr_re_i      : read strobe
//   csr_we_i      : write strobe (full-word write)
//   csr_wdata_i   : write data
//   csr_hit_o     : address belongs to the counter unit
//   csr_rdata_o   : combinational read data
//   csr_illegal_o : access must raise an illegal-instruction exception
// ---------------------------------------------------------------------------
interface riscv_hpm_unit_if #(
    parameter int XLEN = 64
);
    logic [11:0]     csr_addr_i;
    logic            csr_re_i;
    logic            csr_we_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic            csr_hit_o;
    logic [XLEN-1:0] csr_rdata_o;
    logic            csr_illegal_o;

    modport master (
        output csr_addr_i, csr_re_i, csr_we_i, csr_wdata_i,
        input  csr_hit_o, csr_rdata_o, csr_illegal_o
    );

    modport slave (
        input  csr_addr_i, csr_re_i, csr_we_i, csr_wdata_i,
        output csr_hit_o, csr_rdata_o, csr_illegal_o
    );
endinterface

// File: rtl/riscv_hpm_unit.sv
// ---------------------------------------------------------------------------
// riscv_hpm_unit
// Machine/user performance-counter unit: mcycle, minstret, NB_HPM
// mhpmcounter/mhpmevent pairs, mcountinhibit, mcounteren and the read-only
// user shadows. Reads are combinational; writes commit on the next clk edge.
//   clk       : core clock
//   reset_n   : asynchronous active-low reset
//   csr       : CSR access bundle (slave side)
//   events_i  : one-cycle event strobes, event code k selects events_i[k-1]
//   instret_i : instructions retired this cycle
//   priv_i    : current privilege (3=M, 1=S, 0=U)
//   ovf_o     : sticky overflow flags {hpm[NB_HPM-1:0], instret, cycle}
// ---------------------------------------------------------------------------
module riscv_hpm_unit #(
    parameter int XLEN      = 64,
    parameter int NB_HPM    = 14,
    parameter int NB_EVENTS = 14,
    parameter int CNT_WIDTH = 64,
    parameter int RET_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    riscv_hpm_unit_if.slave      csr,
    input  logic [NB_EVENTS-1:0] events_i,
    input  logic [RET_W-1:0]     instret_i,
    input  logic [1:0]           priv_i,
    output logic [NB_HPM+1:0]    ovf_o
);

    // Counter slots that physically exist: 0 (cycle), 2 (instret), 3..3+NB_HPM-1.
    function automatic logic [31:0] impl_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i == 0) || (i == 2) || ((i >= 3) && (i < 3 + NB_HPM));
        end
        return m;
    endfunction

    localparam logic [31:0] IMPL = impl_mask();

    // Overflow bit b belongs to counter slot 0 for b==0, else slot b+1.
    function automatic int cidx(input int b);
        return (b == 0) ? 0 : b + 1;
    endfunction

    // Event codes outside 1..NB_EVENTS never fire.
    function automatic logic evt_fire(input logic [7:0] code, input logic [NB_EVENTS-1:0] ev);
        logic f;
        f = 1'b0;
        for (int k = 1; k <= NB_EVENTS; k++) begin
            if ((code == 8'(k)) && ev[k-1]) f = 1'b1;
        end
        return f;
    endfunction

    logic [CNT_WIDTH-1:0] cnt_q [0:31];
    logic [7:0]           evt_q [0:31];
    logic [NB_HPM+1:0]    ovf_q;
    logic [31:0]          inhibit_q;
    logic [31:0]          counteren_q;
    logic [CNT_WIDTH:0]   sum   [0:31];
    logic [CNT_WIDTH:0]   step;

    logic [11:0] addr;
    logic [4:0]  idx;
    logic        is_cnt, is_evt, is_inh, is_ren, is_shd, m_space, wr_ok;

    assign addr  = csr.csr_addr_i;
    assign idx   = addr[4:0];
    assign ovf_o = ovf_q;

    // Address decode and access legality.
    always_comb begin
        is_cnt  = (addr[11:5] == 7'h58) && (idx != 5'd1);    // 0xB00..0xB1F, no 0xB01
        is_evt  = (addr[11:5] == 7'h19) && (idx >= 5'd3);    // 0x323..0x33F
        is_inh  = (addr == 12'h320);
        is_ren  = (addr == 12'h306);
        is_shd  = (addr[11:5] == 7'h60) && (idx != 5'd1);    // 0xC00..0xC1F, time excluded
        m_space = is_cnt || is_evt || is_inh || is_ren;

        csr.csr_hit_o     = m_space || is_shd;
        csr.csr_illegal_o = (csr.csr_re_i || csr.csr_we_i) &&
                            ((m_space && (priv_i != 2'd3)) ||
                             (is_shd && csr.csr_we_i) ||
                             (is_shd && (priv_i != 2'd3) && !counteren_q[idx]));
        wr_ok = csr.csr_we_i && csr.csr_hit_o && !csr.csr_illegal_o;
    end

    // Read mux; unimplemented slots read as zero.
    always_comb begin
        csr.csr_rdata_o = '0;
        if ((is_cnt || is_shd) && IMPL[idx]) csr.csr_rdata_o = XLEN'(cnt_q[idx]);
        else if (is_evt && IMPL[idx])        csr.csr_rdata_o = XLEN'(evt_q[idx]);
        else if (is_inh)                     csr.csr_rdata_o = XLEN'(inhibit_q);
        else if (is_ren)                     csr.csr_rdata_o = XLEN'(counteren_q);
    end

    // Next count with one spare bit to capture the carry-out.
    always_comb begin
        step = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == 0)      step = (CNT_WIDTH+1)'(1);
            else if (i == 2) step = (CNT_WIDTH+1)'(instret_i);
            else             step = (CNT_WIDTH+1)'(evt_fire(evt_q[i], events_i));
            sum[i] = {1'b0, cnt_q[i]} + step;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
                evt_q[i] <= '0;
            end
            ovf_q       <= '0;
            inhibit_q   <= '0;
            counteren_q <= '0;
        end else begin
            if (wr_ok && is_inh) inhibit_q   <= csr.csr_wdata_i[31:0] & IMPL;
            if (wr_ok && is_ren) counteren_q <= csr.csr_wdata_i[31:0] & IMPL;
            if (wr_ok && is_evt && IMPL[idx]) evt_q[idx] <= csr.csr_wdata_i[7:0];

            // A write to a counter beats its increment and clears its overflow flag.
            for (int b = 0; b < NB_HPM + 2; b++) begin
                if (wr_ok && is_cnt && (idx == 5'(cidx(b)))) begin
                    cnt_q[cidx(b)] <= csr.csr_wdata_i[CNT_WIDTH-1:0];
                    ovf_q[b]       <= 1'b0;
                end else if (!inhibit_q[cidx(b)]) begin
                    cnt_q[cidx(b)] <= sum[cidx(b)][CNT_WIDTH-1:0];
                    if (sum[cidx(b)][CNT_WIDTH]) ovf_q[b] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_hpm_unit.sv
module tb_riscv_hpm_unit;
    localparam int NB_HPM = 4;
    localparam int NB_EV  = 14;

    logic              clk;
    logic              reset_n;
    logic [NB_EV-1:0]  events;
    logic [1:0]        instret;
    logic [1:0]        priv;
    logic [NB_HPM+1:0] ovf;

    int errors = 0;
    int checks = 0;

    riscv_hpm_unit_if #(.XLEN(64)) bus();

    riscv_hpm_unit #(
        .XLEN(64), .NB_HPM(NB_HPM), .NB_EVENTS(NB_EV), .CNT_WIDTH(64), .RET_W(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .csr(bus.slave),
        .events_i(events), .instret_i(instret), .priv_i(priv), .ovf_o(ovf)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // ---------------- behavioural reference model ----------------
    logic [63:0] mc   [32];
    logic [7:0]  mevt [32];
    logic [31:0] movf;
    logic [31:0] minh;
    logic [31:0] mren;

    function automatic bit impl(input int n);
        return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NB_HPM);
    endfunction

    function automatic logic [31:0] impl_bits();
        logic [31:0] m = '0;
        for (int n = 0; n < 32; n++) if (impl(n)) m[n] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 32; n++) begin
            mc[n] = '0;
            mevt[n] = '0;
        end
        movf = '0; minh = '0; mren = '0;
    endtask

    function automatic void mdec(input logic [11:0] a, input logic [1:0] p, input logic re,
                                 input logic we, output logic h, output logic il);
        bit msp, shd;
        int n;
        n   = int'(a[4:0]);
        msp = (a >= 12'hB00 && a <= 12'hB1F && a != 12'hB01) ||
              (a >= 12'h323 && a <= 12'h33F) || a == 12'h320 || a == 12'h306;
        shd = (a >= 12'hC00 && a <= 12'hC1F && a != 12'hC01);
        h   = msp || shd;
        il  = (re || we) && ((msp && p != 2'd3) || (shd && we) || (shd && p != 2'd3 && !mren[n]));
    endfunction

    function automatic logic [63:0] mread(input logic [11:0] a);
        int n;
        n = int'(a[4:0]);
        if ((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hC00 && a <= 12'hC1F))
            return (impl(n) && n != 1) ? mc[n] : 64'h0;
        if (a >= 12'h323 && a <= 12'h33F) return impl(n) ? {56'h0, mevt[n]} : 64'h0;
        if (a == 12'h320) return {32'h0, minh};
        if (a == 12'h306) return {32'h0, mren};
        return 64'h0;
    endfunction

    function automatic logic [NB_HPM+1:0] exp_ovf();
        logic [NB_HPM+1:0] r;
        r[0] = movf[0];
        r[1] = movf[2];
        for (int j = 0; j < NB_HPM; j++) r[2+j] = movf[3+j];
        return r;
    endfunction

    // Applies the counting rules for the inputs presented at the coming edge.
    task automatic model_edge();
        logic h, il, wok;
        logic [11:0] a;
        logic [63:0] wd, inc, nv;
        int code;
        a  = bus.csr_addr_i;
        wd = bus.csr_wdata_i;
        mdec(a, priv, bus.csr_re_i, bus.csr_we_i, h, il);
        wok = bus.csr_we_i && h && !il;
        for (int n = 0; n < 32; n++) begin
            if (!impl(n)) continue;
            if (wok && a == 12'hB00 + 12'(n)) begin
                mc[n] = wd;
                movf[n] = 1'b0;
            end else if (!minh[n]) begin
                code = int'(mevt[n]);
                if (n == 0)      inc = 64'd1;
                else if (n == 2) inc = 64'(instret);
                else             inc = (code >= 1 && code <= NB_EV && events[code-1]) ? 64'd1 : 64'd0;
                nv = mc[n] + inc;
                if (nv < mc[n]) movf[n] = 1'b1;
                mc[n] = nv;
            end
        end
        if (wok && a >= 12'h323 && a <= 12'h33F && impl(int'(a[4:0]))) mevt[a[4:0]] = wd[7:0];
        if (wok && a == 12'h320) minh = wd[31:0] & impl_bits();
        if (wok && a == 12'h306) mren = wd[31:0] & impl_bits();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        if (reset_n) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [63:0] d, output logic h, output logic il);
        bus.csr_addr_i = a;
        bus.csr_we_i   = 1'b0;
        bus.csr_re_i   = 1'b1;
        #1;
        d  = bus.csr_rdata_o;
        h  = bus.csr_hit_o;
        il = bus.csr_illegal_o;
        bus.csr_re_i = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        bus.csr_addr_i  = a;
        bus.csr_wdata_i = d;
        bus.csr_we_i    = 1'b1;
        tick();
        bus.csr_we_i    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [63:0] d; logic h, il;
        reset_n = 1'b0;
        priv = 2'd3; events = '0; instret = 2'd1;
        bus.csr_addr_i = '0; bus.csr_re_i = 0; bus.csr_we_i = 0; bus.csr_wdata_i = '0;
        model_reset();
        tick(); tick();
        checks++;
        if (ovf !== '0) begin errors++; $display("FAIL reset_ovf: got %h want 0", ovf); end
        rd(12'hB00, d, h, il);
        checks++;
        if (d !== 64'h0 || h !== 1'b1 || il !== 1'b0) begin
            errors++; $display("FAIL reset_mcycle: got d=%h hit=%b ill=%b want 0/1/0", d, h, il);
        end
        rd(12'h320, d, h, il);
        checks++;
        if (d !== 64'h0) begin errors++; $display("FAIL reset_inhibit: got %h want 0", d); end
    endtask

    task automatic test_basic_count();
        logic [63:0] d; logic h, il;
        reset_n = 1'b1;
        instret = 2'd1;
        for (int i = 0; i < 10; i++) tick();
        instret = 2'd0;
        rd(12'hB00, d, h, il);
        checks++;
        if (d !== 64'd10) begin errors++; $display("FAIL count_mcycle: got %0d want 10", d); end
        rd(12'hB02, d, h, il);
        checks++;
        if (d !== 64'd10) begin errors++; $display("FAIL count_minstret: got %0d want 10", d); end
        checks++;
        if (ovf !== '0) begin errors++; $display("FAIL count_ovf: got %h want 0", ovf); end
    endtask

    task automatic test_event();
        logic [63:0] d; logic h, il;
        events = 14'b10;               // code 3 still 0 this cycle, no count
        wr(12'h323, 64'd2);
        for (int i = 0; i < 5; i++) begin events = 14'b10; tick(); end
        for (int i = 0; i < 3; i++) begin events = 14'b01; tick(); end
        events = '0;
        rd(12'hB03, d, h, il);
        checks++;
        if (d !== 64'd5) begin errors++; $display("FAIL event_count: got %0d want 5", d); end
        rd(12'h323, d, h, il);
        checks++;
        if (d !== 64'd2) begin errors++; $display("FAIL event_readback: got %0d want 2", d); end
        wr(12'h323, 64'h0);
        for (int i = 0; i < 5; i++) begin events = 14'b11; tick(); end
        events = '0;
        rd(12'hB03, d, h, il);
        checks++;
        if (d !== 64'd5) begin errors++; $display("FAIL event_code0: got %0d want 5", d); end
        wr(12'h324, 64'h1FF);          // only low 8 bits kept
        rd(12'h324, d, h, il);
        checks++;
        if (d !== 64'hFF) begin errors++; $display("FAIL event_8bit: got %h want ff", d); end
        for (int i = 0; i < 4; i++) begin events = '1; tick(); end
        events = '0;
        rd(12'hB04, d, h, il);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL event_badcode: got %0d want 0", d); end
    endtask

    task automatic test_inhibit();
        logic [63:0] d, frozen; logic h, il;
        wr(12'h320, 64'h1);
        frozen = mc[0];
        for (int i = 0; i < 20; i++) tick();
        rd(12'hB00, d, h, il);
        checks++;
        if (d !== frozen) begin errors++; $display("FAIL inhibit_frozen: got %0d want %0d", d, frozen); end
        wr(12'h320, 64'h0);
        tick();
        rd(12'hB00, d, h, il);
        checks++;
        if (d !== frozen + 64'd1) begin
            errors++; $display("FAIL inhibit_resume: got %0d want %0d", d, frozen + 64'd1);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] d; logic h, il;
        instret = 2'd3;                // write beats increment
        wr(12'hB02, 64'hFFFF_FFFF_FFFF_FFFE);
        rd(12'hB02, d, h, il);
        checks++;
        if (d !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL wrap_write: got %h want fffffffffffffffe", d); end
        tick();
        rd(12'hB02, d, h, il);
        checks++;
        if (d !== 64'd1 || ovf[1] !== 1'b1) begin
            errors++; $display("FAIL wrap_ovf: got %h ovf=%b want 1 ovf=1", d, ovf[1]);
        end
        wr(12'hB02, 64'h0);
        instret = 2'd0;
        rd(12'hB02, d, h, il);
        checks++;
        if (d !== 64'd0 || ovf[1] !== 1'b0) begin
            errors++; $display("FAIL wrap_clear: got %h ovf=%b want 0 ovf=0", d, ovf[1]);
        end
    endtask

    task automatic test_priv();
        logic [63:0] d; logic h, il;
        priv = 2'd3;
        wr(12'h306, 64'h0);
        priv = 2'd0;
        rd(12'hC00, d, h, il);
        checks++;
        if (il !== 1'b1 || h !== 1'b1) begin errors++; $display("FAIL priv_shadow_denied: got ill=%b hit=%b want 1/1", il, h); end
        priv = 2'd3;
        wr(12'h306, 64'h1);
        priv = 2'd0;
        rd(12'hC00, d, h, il);
        checks++;
        if (il !== 1'b0 || d !== mc[0]) begin
            errors++; $display("FAIL priv_shadow_ok: got ill=%b d=%0d want 0/%0d", il, d, mc[0]);
        end
        rd(12'hC02, d, h, il);
        checks++;
        if (il !== 1'b1) begin errors++; $display("FAIL priv_instret_denied: got ill=%b want 1", il); end
        rd(12'hB00, d, h, il);
        checks++;
        if (il !== 1'b1) begin errors++; $display("FAIL priv_mspace: got ill=%b want 1", il); end
        bus.csr_addr_i = 12'hC00; bus.csr_wdata_i = 64'h1234; bus.csr_we_i = 1'b1;
        #1;
        checks++;
        if (bus.csr_illegal_o !== 1'b1) begin errors++; $display("FAIL priv_shadow_write: got ill=%b want 1", bus.csr_illegal_o); end
        tick();
        bus.csr_we_i = 1'b0;
        priv = 2'd3;
        rd(12'hB00, d, h, il);
        checks++;
        if (d !== mc[0]) begin errors++; $display("FAIL priv_nochange: got %0d want %0d", d, mc[0]); end
        rd(12'hC01, d, h, il);
        checks++;
        if (h !== 1'b0) begin errors++; $display("FAIL time_nohit: got hit=%b want 0", h); end
    endtask

    task automatic test_unimpl();
        logic [63:0] d; logic h, il;
        priv = 2'd3;
        wr(12'hB10, 64'hDEAD_BEEF);
        rd(12'hB10, d, h, il);
        checks++;
        if (h !== 1'b1 || d !== 64'h0 || il !== 1'b0) begin
            errors++; $display("FAIL unimpl_counter: got hit=%b d=%h ill=%b want 1/0/0", h, d, il);
        end
        wr(12'h306, '1);
        rd(12'h306, d, h, il);
        checks++;
        if (d !== 64'h7D) begin errors++; $display("FAIL counteren_mask: got %h want 7d", d); end
        wr(12'h32A, 64'h3);
        rd(12'h32A, d, h, il);
        checks++;
        if (d !== 64'h0 || h !== 1'b1) begin errors++; $display("FAIL unimpl_event: got %h hit=%b want 0/1", d, h); end
    endtask

    task automatic test_random();
        logic [11:0] alist [20];
        logic [11:0] cl [6];
        logic [63:0] d; logic h, il, eh, eil;
        alist = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB10, 12'h323,
                  12'h324, 12'h326, 12'h320, 12'h306, 12'hC00, 12'hC02, 12'hC03, 12'hC06,
                  12'hC01, 12'hB01, 12'h7C0, 12'hC1F};
        cl = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06};
        for (int it = 0; it < 300; it++) begin
            events  = NB_EV'($urandom);
            instret = 2'($urandom);
            case ($urandom_range(0, 2))
                0: priv = 2'd0;
                1: priv = 2'd1;
                default: priv = 2'd3;
            endcase
            bus.csr_addr_i = alist[$urandom_range(0, 19)];
            bus.csr_we_i   = ($urandom_range(0, 3) == 0);
            bus.csr_re_i   = !bus.csr_we_i && ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: bus.csr_wdata_i = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
                1: bus.csr_wdata_i = 64'($urandom_range(0, 16));
                2: bus.csr_wdata_i = {$urandom, $urandom};
                default: bus.csr_wdata_i = 64'($urandom_range(0, 255)) & 64'hFFFF_FFF2;
            endcase
            #1;
            mdec(bus.csr_addr_i, priv, bus.csr_re_i, bus.csr_we_i, eh, eil);
            checks++;
            if (bus.csr_hit_o !== eh || bus.csr_illegal_o !== eil) begin
                errors++; $display("FAIL rand_decode a=%h: got hit=%b ill=%b want %b/%b",
                                   bus.csr_addr_i, bus.csr_hit_o, bus.csr_illegal_o, eh, eil);
            end
            if (bus.csr_re_i && eh && !eil) begin
                checks++;
                if (bus.csr_rdata_o !== mread(bus.csr_addr_i)) begin
                    errors++; $display("FAIL rand_read a=%h: got %h want %h",
                                       bus.csr_addr_i, bus.csr_rdata_o, mread(bus.csr_addr_i));
                end
            end
            tick();
            bus.csr_we_i = 1'b0;
            priv = 2'd3;
            for (int c = 0; c < 6; c++) begin
                rd(cl[c], d, h, il);
                checks++;
                if (d !== mread(cl[c])) begin
                    errors++; $display("FAIL rand_cnt a=%h: got %h want %h", cl[c], d, mread(cl[c]));
                end
            end
            checks++;
            if (ovf !== exp_ovf()) begin errors++; $display("FAIL rand_ovf: got %b want %b", ovf, exp_ovf()); end
        end
        events = '0; instret = '0;
    endtask

    task automatic test_async_reset();
        logic [63:0] d; logic h, il;
        priv = 2'd3;
        wr(12'h323, 64'd1);
        wr(12'hB06, 64'hFFFF_FFFF_FFFF_FFFF);
        instret = 2'd2;
        tick();
        #3;
        reset_n = 1'b0;
        model_reset();
        rd(12'hB00, d, h, il);
        checks++;
        if (d !== 64'h0 || ovf !== '0) begin errors++; $display("FAIL async_reset: got d=%h ovf=%b want 0/0", d, ovf); end
        rd(12'h323, d, h, il);
        checks++;
        if (d !== 64'h0) begin errors++; $display("FAIL async_reset_evt: got %h want 0", d); end
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rd(12'hB00, d, h, il);
        checks++;
        if (d !== 64'd3) begin errors++; $display("FAIL reset_resume: got %0d want 3", d); end
        rd(12'hB02, d, h, il);
        checks++;
        if (d !== 64'd6) begin errors++; $display("FAIL reset_resume_instret: got %0d want 6", d); end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_event();
        test_inhibit();
        test_wrap();
        test_priv();
        test_unimpl();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
